// File: rtl/interface_hcsr04_multi_if.sv
// Sensor-side bundle for the averaging HC-SR04 interface: request, echo, trigger,
// averaged distance and status, with controller (master) and interface (slave) views.
interface interface_hcsr04_multi_if #(
  parameter int WIDTH = 12
);
  logic             medir;
  logic             echo;
  logic             trigger;
  logic [WIDTH-1:0] medida;
  logic             pronto;
  logic             erro;
  logic [3:0]       db_estado;

  modport master (
    output medir, echo,
    input  trigger, medida, pronto, erro, db_estado
  );

  modport slave (
    input  medir, echo,
    output trigger, medida, pronto, erro, db_estado
  );
endinterface

// File: rtl/interface_hcsr04_multi.sv
// HC-SR04 burst measurement: 2**LOG2_SAMPLES trigger/echo cycles, each echo rounded
// to whole cm, averaged into medida; echo timeout and out-of-range abort with erro.
module interface_hcsr04_multi #(
  parameter int WIDTH          = 12,
  parameter int LOG2_SAMPLES   = 2,
  parameter int CYCLES_PER_CM  = 2941,
  parameter int TRIGGER_CYCLES = 500,
  parameter int TIMEOUT_CYCLES = 1500000,
  parameter int MAX_CM         = 400,
  parameter int GAP_CYCLES     = 3000000
) (
  input logic                    clock,
  input logic                    reset,
  interface_hcsr04_multi_if.slave bus
);

  localparam int NSAMP   = 1 << LOG2_SAMPLES;
  localparam int CM_W    = $clog2(MAX_CM + 2) + 1;
  localparam int SUB_W   = $clog2(CYCLES_PER_CM + 1);
  localparam int IDX_W   = LOG2_SAMPLES + 1;
  localparam int ACC_W   = ((CM_W > WIDTH) ? CM_W : WIDTH) + LOG2_SAMPLES;
  localparam int TMR_MAX = (TIMEOUT_CYCLES > GAP_CYCLES)
                           ? ((TIMEOUT_CYCLES > TRIGGER_CYCLES) ? TIMEOUT_CYCLES : TRIGGER_CYCLES)
                           : ((GAP_CYCLES > TRIGGER_CYCLES) ? GAP_CYCLES : TRIGGER_CYCLES);
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  localparam logic [TMR_W-1:0] TRIG_LAST = TMR_W'(TRIGGER_CYCLES - 1);
  localparam logic [TMR_W-1:0] TOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0] GAP_LAST  = TMR_W'(GAP_CYCLES - 1);
  localparam logic [SUB_W-1:0] SUB_LAST  = SUB_W'(CYCLES_PER_CM - 1);
  localparam logic [SUB_W-1:0] SUB_HALF  = SUB_W'(CYCLES_PER_CM / 2);
  localparam logic [CM_W-1:0]  CM_MAX    = CM_W'(MAX_CM);
  localparam logic [IDX_W-1:0] IDX_END   = IDX_W'(NSAMP);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] TRIG      = 3'd1;
  localparam logic [2:0] WAIT_ECHO = 3'd2;
  localparam logic [2:0] MEASURE   = 3'd3;
  localparam logic [2:0] ACCUM     = 3'd4;
  localparam logic [2:0] GAP       = 3'd5;
  localparam logic [2:0] DONE      = 3'd6;
  localparam logic [2:0] ERR       = 3'd7;

  function automatic logic [CM_W-1:0] round_cm(input logic [CM_W-1:0] cm,
                                               input logic [SUB_W-1:0] res);
    round_cm = (res >= SUB_HALF) ? cm + CM_W'(1) : cm;
  endfunction

  function automatic logic [WIDTH-1:0] sat_avg(input logic [ACC_W-1:0] avg);
    logic [WIDTH-1:0] top;
    top = '1;
    sat_avg = (avg > ACC_W'(top)) ? top : WIDTH'(avg);
  endfunction

  logic             echo_p0, echo_p1;
  logic             medir_p0, medir_pulse;
  logic [2:0]       state;
  logic [TMR_W-1:0] timer;
  logic [SUB_W-1:0] sub_cnt;
  logic [CM_W-1:0]  cm_cnt;
  logic [CM_W-1:0]  sample;
  logic [ACC_W-1:0] acc;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] medida_r;
  logic             erro_r;
  logic             echo_sync;

  // stage p0/p1: two-flop synchroniser for the asynchronous echo pin
  always_ff @(posedge clock) begin
    echo_p0 <= bus.echo;
    echo_p1 <= echo_p0;
  end

  assign echo_sync = echo_p1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      medir_p0    <= 1'b0;
      medir_pulse <= 1'b0;
      state       <= IDLE;
      timer       <= '0;
      sub_cnt     <= '0;
      cm_cnt      <= '0;
      sample      <= '0;
      acc         <= '0;
      idx         <= '0;
      medida_r    <= '0;
      erro_r      <= 1'b0;
    end else begin
      medir_p0    <= bus.medir;
      medir_pulse <= bus.medir & ~medir_p0;
      case (state)
        IDLE: begin
          timer <= '0;
          if (medir_pulse) begin
            acc    <= '0;
            idx    <= '0;
            erro_r <= 1'b0;
            state  <= TRIG;
          end
        end
        TRIG: begin
          if (timer == TRIG_LAST) begin
            timer <= '0;
            state <= WAIT_ECHO;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        WAIT_ECHO: begin
          // expiry wins over a simultaneous echo rise
          if (timer == TOUT_LAST) begin
            timer <= '0;
            state <= ERR;
          end else if (echo_sync) begin
            timer   <= '0;
            sub_cnt <= SUB_W'(1);
            cm_cnt  <= '0;
            state   <= MEASURE;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        MEASURE: begin
          if (cm_cnt > CM_MAX) begin
            state <= ERR;
          end else if (!echo_sync) begin
            sample <= round_cm(cm_cnt, sub_cnt);
            state  <= ACCUM;
          end else if (sub_cnt == SUB_LAST) begin
            sub_cnt <= '0;
            cm_cnt  <= cm_cnt + CM_W'(1);
          end else begin
            sub_cnt <= sub_cnt + SUB_W'(1);
          end
        end
        ACCUM: begin
          acc   <= acc + ACC_W'(sample);
          idx   <= idx + IDX_W'(1);
          timer <= '0;
          state <= (idx + IDX_W'(1) == IDX_END) ? DONE : GAP;
        end
        GAP: begin
          if (timer == GAP_LAST) begin
            timer <= '0;
            state <= TRIG;
          end else begin
            timer <= timer + TMR_W'(1);
          end
        end
        DONE: begin
          medida_r <= sat_avg(acc >> LOG2_SAMPLES);
          erro_r   <= 1'b0;
          state    <= IDLE;
        end
        ERR: begin
          erro_r <= 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.trigger   = (state == TRIG);
  assign bus.pronto    = (state == DONE) || (state == ERR);
  assign bus.medida    = medida_r;
  assign bus.erro      = erro_r;
  assign bus.db_estado = {1'b0, state};

endmodule

// File: tb/tb_interface_hcsr04_multi.sv
// Directed bench for interface_hcsr04_multi with scaled-down timing; expected burst
// results are queued when a burst is launched and checked when pronto appears.
module tb_interface_hcsr04_multi;

  localparam int WIDTH = 12;
  localparam int L2S   = 2;
  localparam int CPC   = 10;
  localparam int TRIG  = 5;
  localparam int TOUT  = 200;
  localparam int MAXCM = 40;
  localparam int GAPC  = 50;

  typedef struct {
    logic [WIDTH-1:0] medida;
    logic             erro;
    logic [3:0]       st;
  } exp_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  interface_hcsr04_multi_if #(.WIDTH(WIDTH)) bus ();

  interface_hcsr04_multi #(
    .WIDTH(WIDTH), .LOG2_SAMPLES(L2S), .CYCLES_PER_CM(CPC), .TRIGGER_CYCLES(TRIG),
    .TIMEOUT_CYCLES(TOUT), .MAX_CM(MAXCM), .GAP_CYCLES(GAPC)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   rise_q[$];
  int   width_err = 0;
  int   pronto_cnt = 0;
  int   run = 0;
  logic trig_prev = 1'b0;

  // trigger/pronto monitor
  always @(negedge clock) begin
    cyc++;
    if (bus.trigger && !trig_prev) rise_q.push_back(cyc);
    if (bus.trigger) run++;
    else begin
      if (trig_prev && run != TRIG) width_err++;
      run = 0;
    end
    trig_prev = bus.trigger;
    if (bus.pronto) pronto_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_trig_fall(input string tag);
    int k;
    k = 0;
    while (!bus.trigger && k < 1000) begin tick(); k++; end
    check({tag, "_trig_rise"}, {31'd0, bus.trigger}, 32'd1);
    k = 0;
    while (bus.trigger && k < 1000) begin tick(); k++; end
    check({tag, "_trig_fall"}, {31'd0, bus.trigger}, 32'd0);
  endtask

  task automatic send_echo(input string tag, input int n);
    wait_trig_fall(tag);
    repeat (3) tick();
    bus.echo = 1'b1;
    repeat (n) tick();
    bus.echo = 1'b0;
  endtask

  task automatic pulse_medir();
    bus.medir = 1'b1;
    tick();
    tick();
    bus.medir = 1'b0;
  endtask

  task automatic start_burst(input logic [WIDTH-1:0] m, input logic e, input logic [3:0] st);
    exp_t x;
    x.medida = m;
    x.erro   = e;
    x.st     = st;
    exp_q.push_back(x);
    pulse_medir();
  endtask

  task automatic wait_done(input string tag);
    int   k;
    exp_t x;
    k = 0;
    while (!bus.pronto && k < 3000) begin tick(); k++; end
    check({tag, "_pronto"}, {31'd0, bus.pronto}, 32'd1);
    x = exp_q.pop_front();
    check({tag, "_state"}, {28'd0, bus.db_estado}, {28'd0, x.st});
    tick();
    check({tag, "_pronto_1cyc"}, {31'd0, bus.pronto}, 32'd0);
    check({tag, "_medida"}, {20'd0, bus.medida}, {20'd0, x.medida});
    check({tag, "_erro"}, {31'd0, bus.erro}, {31'd0, x.erro});
    check({tag, "_idle"}, {28'd0, bus.db_estado}, 32'd0);
  endtask

  task automatic check_triggers(input string tag, input int base);
    int min_sp;
    check({tag, "_trig_count"}, rise_q.size() - base, 32'd4);
    min_sp = 1000000;
    for (int i = base + 1; i < rise_q.size(); i++)
      if (rise_q[i] - rise_q[i-1] < min_sp) min_sp = rise_q[i] - rise_q[i-1];
    check({tag, "_trig_spacing"}, {31'd0, min_sp >= GAPC}, 32'd1);
  endtask

  initial begin
    int base;
    int t;
    bus.medir = 1'b0;
    bus.echo  = 1'b0;
    reset     = 1'b0;
    repeat (3) tick();
    check("rst_trigger", {31'd0, bus.trigger}, 32'd0);
    check("rst_pronto", {31'd0, bus.pronto}, 32'd0);
    check("rst_erro", {31'd0, bus.erro}, 32'd0);
    check("rst_medida", {20'd0, bus.medida}, 32'd0);
    check("rst_state", {28'd0, bus.db_estado}, 32'd0);
    reset = 1'b1;
    tick();

    // four 10 cm echoes, with trigger latency from the medir edge
    exp_q.push_back('{medida: 12'd10, erro: 1'b0, st: 4'd6});
    base = rise_q.size();
    bus.medir = 1'b1;
    tick();
    check("trig_lat1", {31'd0, bus.trigger}, 32'd0);
    tick();
    check("trig_lat2", {31'd0, bus.trigger}, 32'd1);
    bus.medir = 1'b0;
    for (int i = 0; i < 4; i++) send_echo("avg10", 100);
    wait_done("avg10");
    check_triggers("avg10", base);

    // rounding at exactly half a cm and just below
    start_burst(12'd11, 1'b0, 4'd6);
    for (int i = 0; i < 4; i++) send_echo("rnd_up", 105);
    wait_done("rnd_up");
    start_burst(12'd10, 1'b0, 4'd6);
    for (int i = 0; i < 4; i++) send_echo("rnd_dn", 104);
    wait_done("rnd_dn");

    // 10,10,11,11 -> 42>>2 = 10, re-pulsing medir mid-burst
    start_burst(12'd10, 1'b0, 4'd6);
    base = rise_q.size();
    send_echo("avg42", 100);
    pulse_medir();
    send_echo("avg42", 100);
    send_echo("avg42", 110);
    send_echo("avg42", 110);
    wait_done("avg42");
    check_triggers("avg42", base);

    // 40 cm plus a half rounds to MAX_CM+1 and is still accepted
    start_burst(12'd41, 1'b0, 4'd6);
    for (int i = 0; i < 4; i++) send_echo("max_round", 405);
    wait_done("max_round");

    // 11,11,11,12 -> 45>>2 = 11
    start_burst(12'd11, 1'b0, 4'd6);
    send_echo("avg45", 110);
    send_echo("avg45", 110);
    send_echo("avg45", 110);
    send_echo("avg45", 120);
    wait_done("avg45");

    // timeout: no echo at all, medida keeps 11
    start_burst(12'd11, 1'b1, 4'd7);
    wait_trig_fall("tout");
    wait_done("tout");

    // out of range: echo never falls
    start_burst(12'd11, 1'b1, 4'd7);
    wait_trig_fall("oor");
    repeat (3) tick();
    bus.echo = 1'b1;
    t = 0;
    while (!bus.pronto && t < 1000) begin tick(); t++; end
    check("oor_time", {31'd0, (t >= 410 && t <= 416)}, 32'd1);
    wait_done("oor");
    bus.echo = 1'b0;
    repeat (5) tick();

    // next good burst clears erro
    start_burst(12'd12, 1'b0, 4'd6);
    for (int i = 0; i < 4; i++) send_echo("recover", 120);
    wait_done("recover");

    // reset while measuring
    pulse_medir();
    wait_trig_fall("rst_mid");
    repeat (3) tick();
    bus.echo = 1'b1;
    repeat (50) tick();
    check("rst_mid_measure", {28'd0, bus.db_estado}, 32'd3);
    base = pronto_cnt;
    reset = 1'b0;
    tick();
    reset = 1'b1;
    check("rst_mid_trigger", {31'd0, bus.trigger}, 32'd0);
    check("rst_mid_medida", {20'd0, bus.medida}, 32'd0);
    check("rst_mid_erro", {31'd0, bus.erro}, 32'd0);
    check("rst_mid_state", {28'd0, bus.db_estado}, 32'd0);
    repeat (20) tick();
    bus.echo = 1'b0;
    repeat (300) tick();
    check("rst_mid_no_pronto", pronto_cnt - base, 32'd0);
    check("rst_mid_stays_idle", {28'd0, bus.db_estado}, 32'd0);

    check("trig_width", width_err, 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
